// File: rtl/seg_pkg.sv
// Shared types and constants for the seg_scan_display hex display driver.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } snap_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder (dp always off).
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 8-digit hex display of a selectable 32-bit counter, with a
// per-frame shadow refresh and a request/acknowledge snapshot handshake.
//
// state    | meaning
// IDLE     | waiting for SnapReq; a request captures the shadow on this edge
// ACK      | SnapAck is high for this one cycle
// WAIT_LOW | waiting for SnapReq to drop before another capture is allowed
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIV_MAX    = 49999,
  parameter int NUM_DIGITS = 8,
  parameter int BLANK_LZ   = 1
) (
  input  logic        GlobalClock,
  input  logic        Reset,
  input  logic [31:0] CountValue0,
  input  logic [31:0] CountValue1,
  input  logic [31:0] CountValue2,
  input  logic [1:0]  Source,
  input  logic        Freeze,
  input  logic        SnapReq,
  output logic        SnapAck,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic [31:0] Shown
);

  localparam int DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(DIV_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      shadow;
  snap_state_t      state, state_nxt;

  logic        tick;
  logic        frame_start;
  logic        capture;
  logic [31:0] sel_val;
  logic [31:0] shifted;
  logic        blank;
  logic [7:0]  seg_code;

  assign tick        = (div_cnt == DIV_TC);
  assign frame_start = tick && (idx == IDX_LAST);

  always_comb begin
    sel_val = '0;
    case (Source)
      2'd0:    sel_val = CountValue0;
      2'd1:    sel_val = CountValue1;
      2'd2:    sel_val = CountValue2;
      default: sel_val = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (SnapReq) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:      state_nxt = WAIT_LOW;
      WAIT_LOW: if (!SnapReq) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shifting the shadow down to the current digit gives both its nibble and,
  // when the remainder is zero, the leading-zero condition for that digit.
  assign shifted = shadow >> {idx, 2'b00};
  assign blank   = (BLANK_LZ != 0) && (idx != '0) && (shifted == '0);

  hex7seg u_hex7seg (
    .nibble (shifted[3:0]),
    .seg    (seg_code)
  );

  always_ff @(posedge GlobalClock) begin
    if (Reset) begin
      div_cnt <= '0;
      idx     <= '0;
      shadow  <= '0;
      state   <= IDLE;
      SnapAck <= 1'b0;
      AN      <= 8'hFF;
      SEG     <= SEG_BLANK;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

      // Handshake capture wins; both sources write the same sel_val.
      if (capture || (frame_start && !Freeze)) shadow <= sel_val;

      state   <= state_nxt;
      SnapAck <= capture;
      AN      <= ~(8'h01 << idx);
      SEG     <= blank ? SEG_BLANK : seg_code;
    end
  end

  assign Shown = shadow;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display with a 4-clock digit period.
module tb_seg_scan_display;

  logic        GlobalClock = 1'b0;
  logic        Reset;
  logic [31:0] CountValue0, CountValue1, CountValue2;
  logic [1:0]  Source;
  logic        Freeze;
  logic        SnapReq;
  logic        SnapAck;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic [31:0] Shown;

  int n_cmp = 0;
  int n_mis = 0;
  int n     = 0;
  int acks  = 0;

  logic [7:0] an_exp;
  logic [7:0] seg_a [8];
  logic [7:0] seg_b [8];
  logic [7:0] seg_c [8];

  seg_scan_display #(.DIV_MAX(3), .NUM_DIGITS(8), .BLANK_LZ(1)) dut (
    .GlobalClock (GlobalClock),
    .Reset       (Reset),
    .CountValue0 (CountValue0),
    .CountValue1 (CountValue1),
    .CountValue2 (CountValue2),
    .Source      (Source),
    .Freeze      (Freeze),
    .SnapReq     (SnapReq),
    .SnapAck     (SnapAck),
    .AN          (AN),
    .SEG         (SEG),
    .Shown       (Shown)
  );

  always #5 GlobalClock = ~GlobalClock;

  task automatic step();
    @(posedge GlobalClock);
    #1;
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  initial begin
    // Digit glyphs for 12345678, 000000A5 and 00000000, digit 0 first.
    seg_a = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    seg_b = '{8'h92, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    seg_c = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    Reset = 1'b1;
    CountValue0 = 32'h12345678;
    CountValue1 = 32'h0;
    CountValue2 = 32'h0;
    Source = 2'd0;
    Freeze = 1'b0;
    SnapReq = 1'b0;

    step();
    step();
    check("rst_an", {24'h0, AN}, 32'hFF);
    check("rst_seg", {24'h0, SEG}, 32'hFF);
    check("rst_shown", Shown, 32'h0);
    check("rst_ack", {31'h0, SnapAck}, 32'h0);

    Reset = 1'b0;
    n = 0;
    step();
    check("first_an", {24'h0, AN}, 32'hFE);
    check("first_seg", {24'h0, SEG}, 32'hC0);

    run_to(31);
    check("pre_frame_shown", Shown, 32'h0);
    step();
    check("frame1_shown", Shown, 32'h12345678);

    for (int d = 0; d < 8; d++) begin
      an_exp = ~(8'h01 << d);
      for (int k = 0; k < 4; k++) begin
        step();
        check("scan_an", {24'h0, AN}, {24'h0, an_exp});
        if (k == 0) check("scan_seg", {24'h0, SEG}, {24'h0, seg_a[d]});
      end
    end

    CountValue0 = 32'h000000A5;
    run_to(95);
    check("pre_frame3_shown", Shown, 32'h12345678);
    step();
    check("frame3_shown", Shown, 32'h000000A5);
    for (int d = 0; d < 8; d++) begin
      an_exp = ~(8'h01 << d);
      step();
      check("blank_an", {24'h0, AN}, {24'h0, an_exp});
      check("blank_seg", {24'h0, SEG}, {24'h0, seg_b[d]});
      step();
      step();
      step();
    end

    Freeze = 1'b1;
    Source = 2'd1;
    CountValue1 = 32'hCAFEF00D;
    run_to(160);
    check("freeze_frame_a", Shown, 32'h000000A5);
    run_to(193);
    check("freeze_frame_b", Shown, 32'h000000A5);

    run_to(200);
    check("ack_idle", {31'h0, SnapAck}, 32'h0);
    SnapReq = 1'b1;
    acks = 0;
    step();
    check("ack_pulse", {31'h0, SnapAck}, 32'h1);
    check("snap_shown", Shown, 32'hCAFEF00D);
    acks += int'(SnapAck);
    CountValue1 = 32'h11112222;
    for (int i = 0; i < 4; i++) begin
      step();
      acks += int'(SnapAck);
    end
    check("held_one_capture", Shown, 32'hCAFEF00D);
    check("held_one_ack", acks, 32'd1);

    SnapReq = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      acks += int'(SnapAck);
    end
    check("no_ack_low", acks, 32'd0);
    SnapReq = 1'b1;
    step();
    check("reassert_ack", {31'h0, SnapAck}, 32'h1);
    check("reassert_shown", Shown, 32'h11112222);
    SnapReq = 1'b0;

    Freeze = 1'b0;
    Source = 2'd2;
    CountValue2 = 32'h0BADBEEF;
    run_to(223);
    check("pre_simul_shown", Shown, 32'h11112222);
    SnapReq = 1'b1;
    acks = 0;
    step();
    check("simul_shown", Shown, 32'h0BADBEEF);
    check("simul_ack", {31'h0, SnapAck}, 32'h1);
    acks += int'(SnapAck);
    SnapReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      acks += int'(SnapAck);
    end
    check("simul_one_ack", acks, 32'd1);

    run_to(245);
    check("midscan_idx5_an", {24'h0, AN}, 32'hDF);
    Reset = 1'b1;
    step();
    check("mid_rst_an", {24'h0, AN}, 32'hFF);
    check("mid_rst_seg", {24'h0, SEG}, 32'hFF);
    check("mid_rst_shown", Shown, 32'h0);
    check("mid_rst_ack", {31'h0, SnapAck}, 32'h0);

    Source = 2'd3;
    CountValue0 = 32'hFFFFFFFF;
    Reset = 1'b0;
    n = 0;
    step();
    check("rerun_first_an", {24'h0, AN}, 32'hFE);
    check("rerun_first_seg", {24'h0, SEG}, 32'hC0);
    run_to(32);
    check("src3_shown", Shown, 32'h0);
    for (int d = 0; d < 8; d++) begin
      an_exp = ~(8'h01 << d);
      step();
      check("src3_an", {24'h0, AN}, {24'h0, an_exp});
      check("src3_seg", {24'h0, SEG}, {24'h0, seg_c[d]});
      step();
      step();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Time-multiplexed 8-digit hex display driver that consumes the CountValue outputs of the performance counters (cycle count, branch counts) in the single-cycle CPU. It selects one of three 32-bit counter values and holds it in a shadow register. The shadow is refreshed once per display frame, or on demand through a request/acknowledge handshake. The block scans the shadow value onto active-low anode/segment outputs, blanking leading zeros.

Parameters:
DIV_MAX, 49999, prescaler terminal count; the scan advances one digit every DIV_MAX+1 clocks
NUM_DIGITS, 8, number of hex digits scanned (fixed 8 for a 32-bit value)
BLANK_LZ, 1, 1 = blank leading-zero digits (digit 0 is never blanked)

Ports:
GlobalClock  in  1  system clock, all state updates on its rising edge
Reset  in  1  synchronous, active-high reset
CountValue0  in  32  counter source 0
CountValue1  in  32  counter source 1
CountValue2  in  32  counter source 2
Source  in  2  source select: 0/1/2 = CountValue0/1/2, 3 = constant 0
Freeze  in  1  1 = suppress the per-frame shadow refresh
SnapReq  in  1  request an immediate shadow capture (level; handshake)
SnapAck  out  1  one-cycle capture acknowledge
AN  out  8  active-low digit enables, bit i = digit i (digit 0 = least significant nibble)
SEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1
Shown  out  32  current shadow value

Behaviour:
- One clock (GlobalClock); Reset is synchronous and active-high. Reset overrides everything.
- Reset values: div_cnt=0, idx=0, shadow=0, state=IDLE, AN=8'hFF, SEG=8'hFF, SnapAck=0, Shown=0.
- Prescaler: div_cnt counts 0..DIV_MAX, then wraps to 0. tick = (div_cnt==DIV_MAX).
- Digit index: on tick, idx advances modulo NUM_DIGITS.
- Frame start = tick while idx==NUM_DIGITS-1.
- Selected value: sel_val = mux(Source); Source=3 gives 0.
- Shadow update priority, at most one write per cycle:
  1. capture from the handshake;
  2. otherwise, frame start with Freeze=0.
  Both write sel_val of that cycle.
- Handshake FSM:
  - IDLE: SnapReq=1 -> capture shadow this edge; go to ACK.
  - ACK: SnapAck=1 for exactly this cycle; go to WAIT_LOW.
  - WAIT_LOW: stay until SnapReq=0; then return to IDLE.
  - A held SnapReq therefore yields exactly one capture and one ack pulse. Freeze does not block handshake captures.
- Outputs AN and SEG are registered from the idx/shadow values of the previous cycle (1-cycle latency):
  - AN = ~(1<<idx).
  - SEG = hex7seg(nibble idx of shadow), or 8'hFF if blanked.
  - The first cycle after Reset deasserts gives AN=8'hFE.
- Blanking: digit i is blanked when BLANK_LZ=1, i!=0, and nibbles NUM_DIGITS-1..i of shadow are all 0. The anode is still driven; only the segments go off.
- Segment codes (hex 0..F): C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- A mid-scan Reset takes effect at the next edge. No partial frame state survives.

Decomposition:
- Package seg_pkg holds:
  - the FSM state typedef (IDLE, ACK, WAIT_LOW);
  - SEG_BLANK = 8'hFF;
  - the 16-entry active-low hex segment constant table.
- One sub-module, hex7seg: a combinational 4-bit to 8-bit decoder. It is instantiated once on the selected nibble.

Test Plan:
- Reset with DIV_MAX=3: hold Reset 2 cycles -> AN=FF, SEG=FF, Shown=0, SnapAck=0. First cycle after release -> AN=FE, SEG=C0.
- Scan with DIV_MAX=3, Source=0, CountValue0=32'h12345678, Freeze=0: after the first frame start, Shown=12345678. AN steps FE,FD,FB..7F, 4 clocks per digit. Digit0 SEG=80, digit7 SEG=F9.
- Leading-zero blanking: shadow=32'h000000A5 -> digit0 SEG=92, digit1 SEG=88, digits 2..7 SEG=FF while AN still cycles.
- Freeze plus handshake: Freeze=1, CountValue1 changes, Source=1 -> Shown unchanged across 2 frames. SnapReq held 5 cycles -> exactly one capture and SnapAck high for one cycle, on the cycle after SnapReq rises. A second ack occurs only after SnapReq drops and is reasserted.
- Simultaneous events: SnapReq rises in the same cycle as a frame start, with Freeze=0 -> a single shadow write of sel_val and one SnapAck.
- Reset mid-scan and source 3: Reset at idx=5 -> next cycle all reset values. Then Source=3 with CountValue0=FFFFFFFF -> Shown=0 after the next frame start, and AN/SEG shows a single "0" on digit 0.
